// File: rtl/xip_cache_apb.sv
// ---------------------------------------------------------------------------
// xip_cache_apb
// Direct-mapped, one-word-per-line read cache for execute-in-place flash.
// It sits between the CPU-side APB master and the SPI APB bridge.
//   - A flash-window read that hits returns in its first ACCESS cycle and
//     causes no downstream traffic.
//   - A flash-window read miss, and any access outside the window, becomes
//     exactly one downstream APB transfer (states REQ, ACC, RESP).
//   - A write inside the flash window is answered locally with pslverr=1.
//
// Ports
//   clock, reset                    clock; asynchronous active-high reset
//   in_p*                           upstream APB slave port (from the CPU)
//   out_p*                          downstream APB master port (to the bridge)
//   flush                           one-cycle pulse that invalidates every line
//   hit_cnt, miss_cnt               saturating performance counters
//
// Build option
//   XIP_CACHE_PERF_EN  when defined, hit_cnt/miss_cnt are implemented;
//                      otherwise both read as constant zero.
// ---------------------------------------------------------------------------
module xip_cache_apb #(
   parameter logic [31:0] flash_addr_start = 32'h1c000000,
   parameter logic [31:0] flash_addr_end   = 32'h2bffffff,
   parameter int unsigned LINE_NUM         = 16
) (
   input  logic        clock,
   input  logic        reset,
   // upstream request
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   // upstream response
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   // downstream request
   output logic [31:0] out_paddr,
   output logic        out_psel,
   output logic        out_penable,
   output logic [2:0]  out_pprot,
   output logic        out_pwrite,
   output logic [31:0] out_pwdata,
   output logic [3:0]  out_pstrb,
   // downstream response
   input  logic        out_pready,
   input  logic [31:0] out_prdata,
   input  logic        out_pslverr,
   // control / status
   input  logic        flush,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int unsigned IDX  = $clog2(LINE_NUM);
   localparam int unsigned TAGW = 32 - IDX - 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACC  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t              r_state;
   logic [LINE_NUM-1:0] r_valid;
   logic [TAGW-1:0]     r_tag  [LINE_NUM];
   logic [31:0]         r_data [LINE_NUM];

   // latched downstream request and captured response
   logic [31:0] r_out_paddr;
   logic        r_out_psel;
   logic        r_out_penable;
   logic [2:0]  r_out_pprot;
   logic        r_out_pwrite;
   logic [31:0] r_out_pwdata;
   logic [3:0]  r_out_pstrb;
   logic [31:0] r_rdata;
   logic        r_pslverr;
   logic        r_fill;
   logic        r_kill;

   logic            w_access;
   logic            w_xip;
   logic [IDX-1:0]  w_idx;
   logic [TAGW-1:0] w_tag;
   logic            w_hit;
   logic [IDX-1:0]  w_fill_idx;
   logic [TAGW-1:0] w_fill_tag;
   logic            w_line_we;

   // upstream address decode and lookup
   assign w_access = in_psel && in_penable;
   assign w_xip    = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
   assign w_idx    = in_paddr[IDX+1:2];
   assign w_tag    = in_paddr[31:IDX+2];
   assign w_hit    = (r_state == S_IDLE) && w_access && w_xip && !in_pwrite &&
                     r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   // line install on a clean, un-killed fill completion
   assign w_fill_idx = r_out_paddr[IDX+1:2];
   assign w_fill_tag = r_out_paddr[31:IDX+2];
   assign w_line_we  = (r_state == S_ACC) && out_pready && r_fill &&
                       !out_pslverr && !r_kill;

   // transfer sequencer: IDLE -> REQ -> ACC -> RESP -> IDLE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_out_paddr   <= '0;
         r_out_psel    <= 1'b0;
         r_out_penable <= 1'b0;
         r_out_pprot   <= '0;
         r_out_pwrite  <= 1'b0;
         r_out_pwdata  <= '0;
         r_out_pstrb   <= '0;
         r_rdata       <= '0;
         r_pslverr     <= 1'b0;
         r_fill        <= 1'b0;
         r_kill        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access && !w_hit) begin
                  if (w_xip && in_pwrite) begin
                     // writes to flash are refused locally
                     r_rdata   <= '0;
                     r_pslverr <= 1'b1;
                     r_fill    <= 1'b0;
                     r_state   <= S_RESP;
                  end else begin
                     r_out_paddr  <= in_paddr;
                     r_out_pprot  <= in_pprot;
                     r_out_pwrite <= in_pwrite;
                     r_out_pwdata <= in_pwdata;
                     r_out_pstrb  <= in_pstrb;
                     r_out_psel   <= 1'b1;
                     r_fill       <= w_xip;
                     r_state      <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               r_out_penable <= 1'b1;
               r_state       <= S_ACC;
            end
            S_ACC: begin
               if (out_pready) begin
                  r_rdata       <= out_prdata;
                  r_pslverr     <= out_pslverr;
                  r_out_psel    <= 1'b0;
                  r_out_penable <= 1'b0;
                  r_state       <= S_RESP;
               end
            end
            S_RESP: begin
               r_kill  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // a flush racing an in-flight fill must keep that fill out of the array
         if (flush && r_fill && ((r_state == S_REQ) || (r_state == S_ACC)))
            r_kill <= 1'b1;
      end
   end

   // valid bits: flush has priority over a same-cycle install
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else if (w_line_we) begin
         r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // tag and data storage, qualified by r_valid so no reset is needed
   always_ff @(posedge clock) begin
      if (w_line_we) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= out_prdata;
      end
   end

   // upstream response: hits are answered combinationally in IDLE
   assign in_pready  = w_hit || (r_state == S_RESP);
   assign in_prdata  = w_hit ? r_data[w_idx] :
                       ((r_state == S_RESP) ? r_rdata : 32'h0);
   assign in_pslverr = (r_state == S_RESP) && r_pslverr;

   assign out_paddr   = r_out_paddr;
   assign out_psel    = r_out_psel;
   assign out_penable = r_out_penable;
   assign out_pprot   = r_out_pprot;
   assign out_pwrite  = r_out_pwrite;
   assign out_pwdata  = r_out_pwdata;
   assign out_pstrb   = r_out_pstrb;

`ifdef XIP_CACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic        w_fill_start;

   assign w_fill_start = (r_state == S_IDLE) && w_access && !w_hit &&
                         w_xip && !in_pwrite;

   // saturating counters, cleared only by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit && (r_hit_cnt != 32'hffffffff))
            r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_fill_start && (r_miss_cnt != 32'hffffffff))
            r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   assign hit_cnt  = 32'h0;
   assign miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_xip_cache_apb.sv
// ---------------------------------------------------------------------------
// tb_xip_cache_apb
// Directed and randomized bench for xip_cache_apb. An array model of the
// cache (valid/tag/data per line plus hit/fill tallies) predicts every
// upstream response, latency and downstream transfer.
// ---------------------------------------------------------------------------
module tb_xip_cache_apb;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] in_paddr;
   logic        in_psel;
   logic        in_penable;
   logic [2:0]  in_pprot;
   logic        in_pwrite;
   logic [31:0] in_pwdata;
   logic [3:0]  in_pstrb;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;
   logic [31:0] out_paddr;
   logic        out_psel;
   logic        out_penable;
   logic [2:0]  out_pprot;
   logic        out_pwrite;
   logic [31:0] out_pwdata;
   logic [3:0]  out_pstrb;
   logic        out_pready;
   logic [31:0] out_prdata;
   logic        out_pslverr;
   logic        flush;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model
   bit          m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_data  [16];
   int          m_hits;
   int          m_miss;

   always #5 clock = ~clock;

   xip_cache_apb dut (
      .clock      (clock),
      .reset      (reset),
      .in_paddr   (in_paddr),
      .in_psel    (in_psel),
      .in_penable (in_penable),
      .in_pprot   (in_pprot),
      .in_pwrite  (in_pwrite),
      .in_pwdata  (in_pwdata),
      .in_pstrb   (in_pstrb),
      .in_pready  (in_pready),
      .in_prdata  (in_prdata),
      .in_pslverr (in_pslverr),
      .out_paddr  (out_paddr),
      .out_psel   (out_psel),
      .out_penable(out_penable),
      .out_pprot  (out_pprot),
      .out_pwrite (out_pwrite),
      .out_pwdata (out_pwdata),
      .out_pstrb  (out_pstrb),
      .out_pready (out_pready),
      .out_prdata (out_prdata),
      .out_pslverr(out_pslverr),
      .flush      (flush),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", name, obs, exp);
      end
   endtask

   task automatic model_clear();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
   endtask

   task automatic chk_counters();
`ifdef XIP_CACHE_PERF_EN
      chk("hit_cnt", hit_cnt, 32'(m_hits));
      chk("miss_cnt", miss_cnt, 32'(m_miss));
`else
      chk("hit_cnt", hit_cnt, 32'h0);
      chk("miss_cnt", miss_cnt, 32'h0);
`endif
   endtask

   // One upstream APB transfer with a responding downstream slave.
   // k = number of upstream wait states (ACCESS cycles before pready), -1 on timeout.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       input logic [31:0] sdata, input logic serr, input int waits, input bit fl,
                       output logic [31:0] rdata, output logic err, output int k, output int ds,
                       output logic [31:0] d_addr, output logic [31:0] d_wdata,
                       output logic [3:0] d_strb, output logic [2:0] d_prot, output logic d_wr);
      int acc;
      bit flushed;
      bit done;
      acc = 0; flushed = 1'b0; done = 1'b0; k = 0; ds = 0;
      rdata = '0; err = 1'b0; d_addr = '0; d_wdata = '0; d_strb = '0; d_prot = '0; d_wr = 1'b0;
      @(posedge clock); #1;
      in_psel = 1'b1; in_penable = 1'b0; in_paddr = addr; in_pwrite = wr;
      in_pwdata = wdata; in_pstrb = strb; in_pprot = prot;
      @(posedge clock); #1;
      in_penable = 1'b1;
      while (!done && k < 40) begin
         flush = 1'b0;
         out_pready = 1'b0;
         if (out_psel && !out_penable) begin
            ds++;
            d_addr = out_paddr; d_wdata = out_pwdata; d_strb = out_pstrb;
            d_prot = out_pprot; d_wr = out_pwrite;
         end
         if (out_psel && out_penable) begin
            out_pready  = (acc == waits);
            out_prdata  = (acc == waits) ? sdata : $urandom;
            out_pslverr = (acc == waits) ? serr : 1'($urandom_range(0, 1));
            acc++;
            if (fl && !flushed) begin
               flush = 1'b1;
               flushed = 1'b1;
            end
         end
         @(negedge clock);
         if (in_pready) begin
            done = 1'b1;
            rdata = in_prdata;
            err = in_pslverr;
         end else begin
            @(posedge clock); #1;
            k++;
         end
      end
      if (!done) k = -1;
      @(posedge clock); #1;
      in_psel = 1'b0; in_penable = 1'b0; flush = 1'b0; out_pready = 1'b0;
   endtask

   // Run a transfer, predict it from the model, compare, update the model.
   task automatic rc(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] sdata, input logic serr,
                     input int waits, input bit fl, output int o_k, output logic [31:0] o_data);
      logic [31:0] rdata, d_addr, d_wdata, e_data;
      logic [3:0]  d_strb;
      logic [2:0]  prot, d_prot;
      logic        err, d_wr, e_err;
      logic [25:0] tg;
      int          k, ds, e_k, e_ds, ix;
      bit          xip, hit;
      prot = 3'($urandom_range(0, 7));
      xip  = (addr >= 32'h1c000000) && (addr <= 32'h2bffffff);
      ix   = int'(addr[5:2]);
      tg   = addr[31:6];
      hit  = xip && !wr && m_valid[ix] && (m_tag[ix] == tg);
      xfer(addr, wr, wdata, strb, prot, sdata, serr, waits, fl,
           rdata, err, k, ds, d_addr, d_wdata, d_strb, d_prot, d_wr);
      if (hit) begin
         e_data = m_data[ix]; e_err = 1'b0; e_k = 0; e_ds = 0;
         m_hits++;
      end else if (xip && wr) begin
         e_data = 32'h0; e_err = 1'b1; e_k = 1; e_ds = 0;
      end else begin
         e_data = sdata; e_err = serr; e_k = 3 + waits; e_ds = 1;
         if (fl) model_clear();
         if (xip) begin
            m_miss++;
            if (!serr && !fl) begin
               m_valid[ix] = 1'b1; m_tag[ix] = tg; m_data[ix] = sdata;
            end
         end
      end
      chk($sformatf("rdata@%08h", addr), rdata, e_data);
      chk($sformatf("pslverr@%08h", addr), 32'(err), 32'(e_err));
      chk($sformatf("waits@%08h", addr), 32'(k), 32'(e_k));
      chk($sformatf("ds_count@%08h", addr), 32'(ds), 32'(e_ds));
      if (e_ds == 1) begin
         chk($sformatf("ds_paddr@%08h", addr), d_addr, addr);
         chk($sformatf("ds_pwrite@%08h", addr), 32'(d_wr), 32'(wr));
         chk($sformatf("ds_pwdata@%08h", addr), d_wdata, wdata);
         chk($sformatf("ds_pstrb@%08h", addr), 32'(d_strb), 32'(strb));
         chk($sformatf("ds_pprot@%08h", addr), 32'(d_prot), 32'(prot));
      end
      chk_counters();
      o_k = k;
      o_data = rdata;
   endtask

   task automatic pulse_flush();
      @(posedge clock); #1;
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      model_clear();
   endtask

   initial begin
      int          k;
      logic [31:0] d;
      reset = 1'b1;
      in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pprot = '0;
      in_pwrite = 1'b0; in_pwdata = '0; in_pstrb = '0;
      out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0; flush = 1'b0;
      model_clear(); m_hits = 0; m_miss = 0;
      repeat (3) @(posedge clock);
      #1;
      // reset state
      chk("rst_in_pready", 32'(in_pready), 32'h0);
      chk("rst_in_prdata", in_prdata, 32'h0);
      chk("rst_in_pslverr", 32'(in_pslverr), 32'h0);
      chk("rst_out_psel", 32'(out_psel), 32'h0);
      chk("rst_out_penable", 32'(out_penable), 32'h0);
      chk("rst_out_pwrite", 32'(out_pwrite), 32'h0);
      chk("rst_out_paddr", out_paddr, 32'h0);
      chk("rst_out_pwdata", out_pwdata, 32'h0);
      chk("rst_out_pstrb", 32'(out_pstrb), 32'h0);
      chk("rst_out_pprot", 32'(out_pprot), 32'h0);
      chk_counters();
      @(negedge clock);
      reset = 1'b0;

      // cold miss, then hit
      rc(32'h1c000010, 1'b0, 32'h0, 4'h0, 32'hdeadbeef, 1'b0, 0, 1'b0, k, d);
      chk("cold_rdata", d, 32'hdeadbeef);
      chk("cold_latency", 32'(k), 32'd3);
      rc(32'h1c000010, 1'b0, 32'h0, 4'h0, 32'h11111111, 1'b0, 0, 1'b0, k, d);
      chk("hit_rdata", d, 32'hdeadbeef);
      chk("hit_latency", 32'(k), 32'd0);

      // same index, different tag replaces the line
      rc(32'h1c000050, 1'b0, 32'h0, 4'h0, 32'h12345678, 1'b0, 0, 1'b0, k, d);
      chk("conflict_latency", 32'(k), 32'd3);
      rc(32'h1c000010, 1'b0, 32'h0, 4'h0, 32'hcafef00d, 1'b0, 1, 1'b0, k, d);
      chk("replaced_rdata", d, 32'hcafef00d);
      rc(32'h1c000050, 1'b0, 32'h0, 4'h0, 32'h22222222, 1'b0, 0, 1'b0, k, d);
      chk("evicted_rdata", d, 32'h22222222);

      // non-flash write forwarded with 2 slave waits
      rc(32'h10001004, 1'b1, 32'ha5a5a5a5, 4'hf, 32'h0, 1'b0, 2, 1'b0, k, d);
      chk("fwd_write_latency", 32'(k), 32'd5);

      // flash write refused locally
      rc(32'h1c000000, 1'b1, 32'h5a5a5a5a, 4'h3, 32'h0, 1'b0, 0, 1'b0, k, d);

      // flush during ACC of a fill (kill path, then flush/install same cycle)
      rc(32'h1c000020, 1'b0, 32'h0, 4'h0, 32'h0badf00d, 1'b0, 2, 1'b1, k, d);
      chk("flush_fill_rdata", d, 32'h0badf00d);
      rc(32'h1c000020, 1'b0, 32'h0, 4'h0, 32'h33333333, 1'b0, 0, 1'b0, k, d);
      chk("after_flush_miss", 32'(k), 32'd3);
      rc(32'h1c000024, 1'b0, 32'h0, 4'h0, 32'h44444444, 1'b0, 0, 1'b1, k, d);
      rc(32'h1c000024, 1'b0, 32'h0, 4'h0, 32'h55555555, 1'b0, 0, 1'b0, k, d);
      chk("flush_wins_miss", d, 32'h55555555);

      // erroring fill is not installed
      rc(32'h1c000028, 1'b0, 32'h0, 4'h0, 32'h66666666, 1'b1, 1, 1'b0, k, d);
      rc(32'h1c000028, 1'b0, 32'h0, 4'h0, 32'h77777777, 1'b0, 0, 1'b0, k, d);
      chk("err_fill_refetch", 32'(k), 32'd3);

      // window boundaries
      rc(32'h2bfffffc, 1'b0, 32'h0, 4'h0, 32'h88888888, 1'b0, 0, 1'b0, k, d);
      rc(32'h2bfffffc, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0, 1'b0, k, d);
      chk("top_of_window_hit", 32'(k), 32'd0);
      rc(32'h1bfffffc, 1'b0, 32'h0, 4'h0, 32'h99999999, 1'b0, 0, 1'b0, k, d);
      rc(32'h1bfffffc, 1'b0, 32'h0, 4'h0, 32'haaaaaaaa, 1'b0, 0, 1'b0, k, d);
      chk("below_window_fwd", 32'(k), 32'd3);
      rc(32'h2c000000, 1'b0, 32'h0, 4'h0, 32'hbbbbbbbb, 1'b0, 0, 1'b0, k, d);
      rc(32'h1c000000, 1'b0, 32'h0, 4'h0, 32'hcccccccc, 1'b0, 0, 1'b0, k, d);
      rc(32'h1c000000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0, 1'b0, k, d);
      chk("bottom_of_window_hit", d, 32'hcccccccc);

      // standalone flush
      pulse_flush();
      rc(32'h1c000000, 1'b0, 32'h0, 4'h0, 32'hdddddddd, 1'b0, 0, 1'b0, k, d);

      // reset in the middle of a fill aborts it
      @(posedge clock); #1;
      in_psel = 1'b1; in_penable = 1'b0; in_paddr = 32'h1c000030; in_pwrite = 1'b0;
      @(posedge clock); #1;
      in_penable = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("pre_reset_penable", 32'(out_penable), 32'h1);
      reset = 1'b1;
      #1;
      chk("reset_abort_psel", 32'(out_psel), 32'h0);
      chk("reset_abort_penable", 32'(out_penable), 32'h0);
      in_psel = 1'b0; in_penable = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      model_clear(); m_hits = 0; m_miss = 0;
      chk_counters();
      rc(32'h1c000030, 1'b0, 32'h0, 4'h0, 32'heeeeeeee, 1'b0, 0, 1'b0, k, d);
      rc(32'h1c000000, 1'b0, 32'h0, 4'h0, 32'hffff0000, 1'b0, 0, 1'b0, k, d);
      chk("post_reset_miss", 32'(k), 32'd3);

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         int          kind;
         logic [31:0] a;
         logic        w;
         kind = $urandom_range(0, 11);
         w = 1'b0;
         if (kind <= 5)
            a = 32'h1c000000 + (32'($urandom_range(0, 2)) << 6) + (32'($urandom_range(0, 3)) << 2);
         else if (kind == 6)
            a = 32'h2bffffc0 + (32'($urandom_range(0, 15)) << 2);
         else if (kind == 7) begin
            a = 32'h1c000000 + (32'($urandom_range(0, 15)) << 2);
            w = 1'b1;
         end else if (kind <= 9) begin
            a = 32'h10000000 | ($urandom & 32'h00fffffc);
            w = 1'($urandom_range(0, 1));
         end else begin
            if (kind == 11) pulse_flush();
            a = 32'h1c000000 + (32'($urandom_range(0, 3)) << 2);
         end
         rc(a, w, $urandom, 4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0), k, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
